spi_slave_resp: RTL
===================

# spi_slave_resp

SPI responder (slave) that forms the far end of the `spi_miso` initiator. It sits behind the chip-select and serial lines driven by the initiator and decodes a one-byte command (R/W flag plus address) shifted in MSB-first on MOSI. It then either returns register contents on MISO or captures write data into a local 16-entry byte register bank. A side read port exposes the bank to local logic.

## Interface
Parameters:
- `DATA_W`, 8: data and command byte width.
- `DEPTH`, 16: register bank entries; must be a power of two.
- `AW`, 4: log2(DEPTH), the index width.

Ports:
- `spi_clk`  in  1  single clock; all state updates on posedge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `spi_cs`  in  1  chip select, active low, sampled synchronously.
- `spi_mosi_in`  in  1  serial data from the initiator, MSB first.
- `spi_miso_out`  out  1  registered serial data to the initiator, MSB first.
- `miso_oe`  out  1  high while `spi_miso_out` carries valid read data.
- `rx_byte`  out  DATA_W  last completed write-data byte.
- `rx_valid`  out  1  one-cycle pulse when `rx_byte` and the bank update.
- `busy`  out  1  high in any state other than IDLE.
- `host_addr`  in  AW  local read index.
- `host_rdata`  out  DATA_W  combinational `bank[host_addr]`.

## Operation
- Command byte, first 8 bits after `spi_cs` falls:
  - bit7 = 1 selects write, 0 selects read.
  - bits[6:0] give the address, taken modulo DEPTH (low AW bits).
- States:
  - IDLE: waiting. Moves to CMD on the first posedge with `spi_cs`=0. That same edge samples command bit7.
  - CMD: shifts the remaining command bits. On the 8th command bit, moves to WR or RD.
  - RD: shifts out `bank[addr]`. After 8 bits, addr increments and the next byte is reloaded (burst).
  - WR: shifts in 8 bits. On the 8th bit: `bank[addr]` is written, `rx_byte` is updated, `rx_valid` pulses, and addr increments (burst).
- Any posedge with `spi_cs`=1 returns to IDLE. Bit counter and shift registers clear. A partial write byte is discarded and the bank is untouched.
- Address wrap: DEPTH-1 increments to 0.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.
- `miso_oe` = 1 only in RD. In every other state `spi_miso_out` = 0.

## Timing
- Reset values: `spi_miso_out`=0, `miso_oe`=0, `rx_byte`=0, `rx_valid`=0, `busy`=0, all bank entries 0, state IDLE.
- Reset asserted mid-transfer aborts immediately with the same reset values.
- Command: 8 posedges with CS low; edges E1..E8 sample bits 7..0.
- Read path:
  - On E8, the shift register loads `bank[addr]` and `spi_miso_out` shows bit7 after E8.
  - Each following posedge (E9..E15) advances one bit, so bit0 is visible after E15.
  - On E16 the next byte's bit7 appears; no dead cycle between bytes.
  - The initiator samples MISO on the posedge after each change.
- Write path:
  - Data bits are sampled on E9..E16.
  - Bank write happens at E16. `rx_valid` is high for the cycle after E16 only.
  - `host_rdata` reflects the new value after E16.
- CS high and a byte-complete edge in the same cycle: CS wins, nothing is written.
- `busy` goes high after E1 and low after the first posedge with CS high.

## Structure
- Shared package `spi_pkg`:
  - state enum: IDLE, CMD, RD, WR.
  - `SPI_CMD_WR_BIT` = 7.
  - `DATA_W` default.
- One sub-module, `spi_reg_bank`:
  - DEPTH×DATA_W flops with asynchronous reset.
  - One synchronous write port.
  - Two combinational read ports: the shift-load port and the host port.
- The top level holds the FSM, bit counter, shift registers and address counter.

## Test plan
- Write 0x85 then data 0xA5: `bank[5]`=0xA5, `rx_byte`=0xA5, `rx_valid` pulses one cycle after E16, `host_rdata`(5)=0xA5.
- After the write above, read command 0x05: MISO shows 1,0,1,0,0,1,0,1 after E8..E15, `miso_oe`=1 throughout.
- Read 0x2D after reset: returns `bank[13]` = 0x00. MISO stays 0 for 8 bits, `miso_oe`=1.
- Burst write 0x8F with data 0x11, 0x22: `bank[15]`=0x11, `bank[0]`=0x22 (wrap), two `rx_valid` pulses 8 cycles apart.
- Write 0x83, then CS high after 4 data bits: `bank[3]` stays 0, no `rx_valid`, `busy` drops and the FSM returns to IDLE.
- Assert `n_reset` low during a read burst: all outputs go to reset values immediately, the bank clears, and the next CS-low transfer decodes a fresh command.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder and its register bank.
package spi_pkg;

    localparam int SPI_DATA_W     = 8;
    localparam int SPI_CMD_WR_BIT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_reg_bank.sv
// Byte register bank: one synchronous write port, two combinational read ports
// (shift-register load and local host access).
module spi_reg_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     ld_addr,
    output logic [DATA_W-1:0] ld_data,
    input  logic [AW-1:0]     host_addr,
    output logic [DATA_W-1:0] host_rdata
);

    logic [DATA_W-1:0] bank [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_en) begin
            bank[wr_addr] <= wr_data;
        end
    end

    assign ld_data    = bank[ld_addr];
    assign host_rdata = bank[host_addr];

endmodule

// File: rtl/spi_slave_resp.sv
// SPI responder: decodes a R/W + address command byte, then streams bank
// contents out on MISO or captures bytes into the bank, with burst addressing.
module spi_slave_resp
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              spi_clk,
    input  logic              n_reset,
    input  logic              spi_cs,
    input  logic              spi_mosi_in,
    output logic              spi_miso_out,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_byte,
    output logic              rx_valid,
    output logic              busy,
    input  logic [AW-1:0]     host_addr,
    output logic [DATA_W-1:0] host_rdata
);

    spi_state_t        state;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] cmd_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [AW-1:0]     addr;

    logic [DATA_W-1:0] cmd_full;
    logic [DATA_W-1:0] rx_full;
    logic [DATA_W-1:0] ld_data;
    logic [AW-1:0]     ld_addr;
    logic              byte_done;
    logic              wr_en;

    assign cmd_full  = {cmd_sr[DATA_W-2:0], spi_mosi_in};
    assign rx_full   = {rx_sr[DATA_W-2:0], spi_mosi_in};
    assign byte_done = (bit_cnt == 3'd7);
    // First read byte comes from the address being decoded this edge; later ones from addr+1.
    assign ld_addr   = (state == CMD) ? cmd_full[AW-1:0] : addr + AW'(1);
    assign wr_en     = !spi_cs && (state == WR) && byte_done;

    spi_reg_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_bank (
        .clk        (spi_clk),
        .rst_n      (n_reset),
        .wr_en      (wr_en),
        .wr_addr    (addr),
        .wr_data    (rx_full),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .host_addr  (host_addr),
        .host_rdata (host_rdata)
    );

    always_ff @(posedge spi_clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            cmd_sr       <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            addr         <= '0;
            spi_miso_out <= 1'b0;
            miso_oe      <= 1'b0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (spi_cs) begin
                state        <= IDLE;
                bit_cnt      <= '0;
                cmd_sr       <= '0;
                tx_sr        <= '0;
                rx_sr        <= '0;
                spi_miso_out <= 1'b0;
                miso_oe      <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CMD;
                        busy    <= 1'b1;
                        cmd_sr  <= cmd_full;
                        bit_cnt <= 3'd1;
                    end
                    CMD: begin
                        cmd_sr  <= cmd_full;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            addr <= cmd_full[AW-1:0];
                            if (cmd_full[SPI_CMD_WR_BIT]) begin
                                state <= WR;
                            end else begin
                                state        <= RD;
                                tx_sr        <= ld_data;
                                spi_miso_out <= ld_data[DATA_W-1];
                                miso_oe      <= 1'b1;
                            end
                        end
                    end
                    RD: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            addr         <= addr + AW'(1);
                            tx_sr        <= ld_data;
                            spi_miso_out <= ld_data[DATA_W-1];
                        end else begin
                            tx_sr        <= tx_sr << 1;
                            spi_miso_out <= tx_sr[DATA_W-2];
                        end
                    end
                    WR: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        rx_sr   <= rx_full;
                        if (byte_done) begin
                            rx_byte  <= rx_full;
                            rx_valid <= 1'b1;
                            addr     <= addr + AW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
